xgmii_rx_monitor: RTL

- Passive monitor on the 64-bit XGMII receive interface between the 10G BASE-R PHY wrapper and the core logic.
- Tracks frame boundaries and counts good and bad frames.
- Detects local and remote fault ordered sets and derives a link-up status.
- Drives a pulse-stretched activity indicator for the board LEDs.
- Does not modify or forward data; it taps the XGMII receive bus only.

---
 rtl/xgmii_rx_monitor.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/xgmii_rx_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : xgmii_rx_monitor
//  Purpose  : Passive tap on the 64-bit XGMII receive bus. Tracks frame
//             boundaries, counts good and bad frames, detects local/remote
//             fault ordered sets, derives link status and drives a
//             pulse-stretched activity LED. Never modifies the data path.
//  Ports    : clk, rst             - receive clock, synchronous active-high reset
//             xgmii_rxd/xgmii_rxc  - 8 lanes of data + per-lane control flags
//             rx_block_lock        - PHY block lock
//             clear_counters       - synchronous clear of both frame counters
//             good_frame_count     - cleanly terminated frames (saturating)
//             bad_frame_count      - errored or truncated frames (saturating)
//             local_fault, remote_fault, link_up, activity_led - status
//  Revision : 1.0 - initial release
// ============================================================================
module xgmii_rx_monitor #(
  parameter int COUNT_WIDTH  = 32,
  parameter int ACT_STRETCH  = 7812500,
  parameter int FAULT_THRESH = 4,
  parameter int FAULT_CLEAR  = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [63:0]            xgmii_rxd,
  input  logic [7:0]             xgmii_rxc,
  input  logic                   rx_block_lock,
  input  logic                   clear_counters,
  output logic [COUNT_WIDTH-1:0] good_frame_count,
  output logic [COUNT_WIDTH-1:0] bad_frame_count,
  output logic                   local_fault,
  output logic                   remote_fault,
  output logic                   link_up,
  output logic                   activity_led
);

  localparam int ACT_W = $clog2(ACT_STRETCH + 1);
  localparam int HIT_W = $clog2(FAULT_THRESH + 1);
  localparam int GAP_W = $clog2(FAULT_CLEAR + 1);

  localparam logic [7:0]       c_start    = 8'hFB;
  localparam logic [7:0]       c_term     = 8'hFD;
  localparam logic [7:0]       c_seq      = 8'h9C;
  localparam logic [ACT_W-1:0] c_act_load = ACT_W'(ACT_STRETCH - 1);
  localparam logic [HIT_W-1:0] c_hit_max  = HIT_W'(FAULT_THRESH);
  localparam logic [GAP_W-1:0] c_gap_max  = GAP_W'(FAULT_CLEAR);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   err_q, err_d;
  logic [COUNT_WIDTH-1:0] good_q, good_d;
  logic [COUNT_WIDTH-1:0] bad_q, bad_d;
  logic [ACT_W-1:0]       act_q, act_d;
  logic                   led_q, led_d;
  logic                   link_q, link_d;

  logic                   good_inc;
  logic [1:0]             bad_inc;   // up to three bad ends can land in one word
  logic                   frame_end;
  logic [COUNT_WIDTH:0]   good_sum;
  logic [COUNT_WIDTH:0]   bad_sum;

  logic [1:0]             fault_word;    // [0] local, [1] remote
  logic [1:0]             fault_status;

  // One 4-lane half of the word carrying a fault ordered set:
  // Sequence control char in its first byte, then 00, 00, <code>.
  function automatic logic lane_match(input logic [31:0] d, input logic [3:0] c,
                                      input logic [7:0] code);
    return (c == 4'b0001) && (d == {code, 8'h00, 8'h00, c_seq});
  endfunction

  // --------------------------------------------------------------------------
  // Frame tracking: walk the eight lanes in order. A Start in lane 0/4 opens
  // (or, if already open, truncates and reopens) a frame; within a frame the
  // first Terminate closes it and everything after it in the word is ignored.
  // Any other control character inside a frame (Error, Idle, Sequence, a
  // misplaced Start) marks the frame bad.
  // --------------------------------------------------------------------------
  always_comb begin
    logic in_frame;
    logic ended;
    state_d  = state_q;
    err_d    = err_q;
    good_inc = 1'b0;
    bad_inc  = 2'd0;
    in_frame = (state_q == ST_IN_FRAME);
    ended    = 1'b0;

    if (rx_block_lock) begin
      for (int i = 0; i < 8; i++) begin
        if (!ended) begin
          if (xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == c_start) && (i == 0 || i == 4)) begin
            if (in_frame) begin
              bad_inc = bad_inc + 2'd1;
            end
            in_frame = 1'b1;
            err_d    = 1'b0;
          end else if (in_frame && xgmii_rxc[i]) begin
            if (xgmii_rxd[8*i +: 8] == c_term) begin
              if (err_d) begin
                bad_inc = bad_inc + 2'd1;
              end else begin
                good_inc = 1'b1;
              end
              in_frame = 1'b0;
              ended    = 1'b1;
              err_d    = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      state_d = in_frame ? ST_IN_FRAME : ST_IDLE;
    end else begin
      // Loss of lock silently drops any frame in progress.
      state_d = ST_IDLE;
      err_d   = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Counters, activity stretch and link status
  // --------------------------------------------------------------------------
  always_comb begin
    frame_end = good_inc | (bad_inc != 2'd0);

    good_sum = {1'b0, good_q} + (COUNT_WIDTH + 1)'(good_inc);
    bad_sum  = {1'b0, bad_q} + (COUNT_WIDTH + 1)'(bad_inc);

    if (clear_counters) begin
      good_d = '0;
      bad_d  = '0;
    end else begin
      good_d = good_sum[COUNT_WIDTH] ? '1 : good_sum[COUNT_WIDTH-1:0];
      bad_d  = bad_sum[COUNT_WIDTH]  ? '1 : bad_sum[COUNT_WIDTH-1:0];
    end

    if (frame_end) begin
      act_d = c_act_load;
    end else if (act_q != '0) begin
      act_d = act_q - ACT_W'(1);
    end else begin
      act_d = act_q;
    end
    // The load cycle lights the LED as well, so it stays on for ACT_STRETCH
    // cycles in total while the counter runs down from ACT_STRETCH-1.
    led_d = frame_end | (act_q != '0);

    link_d = rx_block_lock & ~fault_status[0] & ~fault_status[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      good_q  <= '0;
      bad_q   <= '0;
      act_q   <= '0;
      led_q   <= 1'b0;
      link_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      act_q   <= act_d;
      led_q   <= led_d;
      link_q  <= link_d;
    end
  end

  // --------------------------------------------------------------------------
  // Fault detection: a hit counter (saturating at the threshold) asserts the
  // fault, a run of clean words deasserts it and forgets the earlier hits.
  // --------------------------------------------------------------------------
  assign fault_word[0] = lane_match(xgmii_rxd[31:0],  xgmii_rxc[3:0], 8'h01) |
                         lane_match(xgmii_rxd[63:32], xgmii_rxc[7:4], 8'h01);
  assign fault_word[1] = lane_match(xgmii_rxd[31:0],  xgmii_rxc[3:0], 8'h02) |
                         lane_match(xgmii_rxd[63:32], xgmii_rxc[7:4], 8'h02);

  generate
    for (genvar f = 0; f < 2; f++) begin : g_fault
      logic [HIT_W-1:0] hit_q, hit_d;
      logic [GAP_W-1:0] gap_q, gap_d;
      logic             flt_q, flt_d;

      always_comb begin
        hit_d = hit_q;
        gap_d = gap_q;
        flt_d = flt_q;
        if (!rx_block_lock) begin
          hit_d = '0;
          gap_d = '0;
        end else if (fault_word[f]) begin
          gap_d = '0;
          if (hit_q != c_hit_max) begin
            hit_d = hit_q + HIT_W'(1);
          end
          if (hit_d == c_hit_max) begin
            flt_d = 1'b1;
          end
        end else begin
          if (gap_q != c_gap_max) begin
            gap_d = gap_q + GAP_W'(1);
          end
          if (gap_d == c_gap_max) begin
            flt_d = 1'b0;
            hit_d = '0;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          hit_q <= '0;
          gap_q <= '0;
          flt_q <= 1'b0;
        end else begin
          hit_q <= hit_d;
          gap_q <= gap_d;
          flt_q <= flt_d;
        end
      end

      assign fault_status[f] = flt_q;
    end
  endgenerate

  assign good_frame_count = good_q;
  assign bad_frame_count  = bad_q;
  assign local_fault      = fault_status[0];
  assign remote_fault     = fault_status[1];
  assign link_up          = link_q;
  assign activity_led     = led_q;

endmodule
`default_nettype wire
